// File: rtl/csa_accumulator_if.sv
// ---------------------------------------------------------------------------
// csa_accumulator_if
//
// Groups the operand-beat and result handshakes of csa_accumulator.
//   in_valid / in_ready / in_0 / in_1 / in_last : operand beat channel
//   out_valid / out_ready                        : result handshake
//   out_result : binary (sum + carry) of the closed group
//   out_sum / out_carry : redundant pair, carry already weight-aligned
//   out_count  : number of beats in the group (wraps)
// slave  modport: the accumulator itself.
// master modport: the producer/consumer around it.
// ---------------------------------------------------------------------------
interface csa_accumulator_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_0;
    logic [WIDTH-1:0]     in_1;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_result;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [ACC_WIDTH-1:0] out_carry;
    logic [CNT_WIDTH-1:0] out_count;

    modport slave (
        input  in_valid, in_0, in_1, in_last, out_ready,
        output in_ready, out_valid, out_result, out_sum, out_carry, out_count
    );

    modport master (
        output in_valid, in_0, in_1, in_last, out_ready,
        input  in_ready, out_valid, out_result, out_sum, out_carry, out_count
    );
endinterface

// File: rtl/csa_accumulator.sv
// ---------------------------------------------------------------------------
// csa_accumulator
//
// Sequential carry-save accumulator. Every accepted beat folds two operands
// into a redundant sum/carry pair through one 4:2 compressor row, so no
// carry ripples per beat. The beat flagged last moves the block into a
// one-cycle resolve stage that adds the pair into a binary result, after
// which the result, the redundant pair and the beat count are held on the
// output handshake until the consumer takes them.
//
// Ports:
//   clock : rising-edge clock for all state
//   reset : synchronous, active-high; discards any partial group
//   bus   : csa_accumulator_if.slave (operand beats in, result out)
//
// Parameters: WIDTH >= 2, ACC_WIDTH >= WIDTH+1, CNT_WIDTH, SIGNED (1 =
// sign-extend operands, 0 = zero-extend). Arithmetic is mod 2^ACC_WIDTH.
// ---------------------------------------------------------------------------
module csa_accumulator #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 8,
    parameter bit SIGNED    = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    csa_accumulator_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_ACC     = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic [ACC_WIDTH-1:0] carry_q, carry_d;
    logic [ACC_WIDTH-1:0] result_q, result_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 in_ready_c;
    logic                 out_valid_c;

    logic [ACC_WIDTH-1:0] x_ext, y_ext;
    logic [ACC_WIDTH-1:0] fa1_s, fa1_c;
    logic [ACC_WIDTH-1:0] row_s, row_c;
    logic [ACC_WIDTH-1:0] row_cin;
    logic                 unused_row_msb;

    // Operand extension to accumulator width.
    generate
        if (SIGNED) begin : g_sext
            assign x_ext = {{(ACC_WIDTH-WIDTH){bus.in_0[WIDTH-1]}}, bus.in_0};
            assign y_ext = {{(ACC_WIDTH-WIDTH){bus.in_1[WIDTH-1]}}, bus.in_1};
        end else begin : g_zext
            assign x_ext = {{(ACC_WIDTH-WIDTH){1'b0}}, bus.in_0};
            assign y_ext = {{(ACC_WIDTH-WIDTH){1'b0}}, bus.in_1};
        end
    endgenerate

    // 4:2 compressor row: first full adder folds (sum, carry, x); its carry
    // travels one column left as the cin of the second full adder, which
    // folds (fa1_s, y, cin). The second adder's carry becomes the new
    // carry vector after a one-bit left shift.
    assign row_cin[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < ACC_WIDTH; gi++) begin : g_row
            assign fa1_s[gi] = sum_q[gi] ^ carry_q[gi] ^ x_ext[gi];
            assign fa1_c[gi] = (sum_q[gi] & carry_q[gi])
                             | (sum_q[gi] & x_ext[gi])
                             | (carry_q[gi] & x_ext[gi]);
            assign row_s[gi] = fa1_s[gi] ^ y_ext[gi] ^ row_cin[gi];
            assign row_c[gi] = (fa1_s[gi] & y_ext[gi])
                             | (fa1_s[gi] & row_cin[gi])
                             | (y_ext[gi] & row_cin[gi]);
            if (gi < ACC_WIDTH - 1) begin : g_chain
                assign row_cin[gi+1] = fa1_c[gi];
            end
        end
    endgenerate

    // Both MSB carries carry weight 2^ACC_WIDTH and vanish modulo the width.
    assign unused_row_msb = fa1_c[ACC_WIDTH-1] ^ row_c[ACC_WIDTH-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_ACC;
            sum_q    <= '0;
            carry_q  <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            ST_ACC: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    sum_d   = row_s;
                    carry_d = {row_c[ACC_WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    if (bus.in_last) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                result_d = sum_q + carry_q;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid_c = 1'b1;
                // result_q is kept so the last result stays visible.
                if (bus.out_ready) begin
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_result = result_q;
    assign bus.out_sum    = sum_q;
    assign bus.out_carry  = carry_q;
    assign bus.out_count  = cnt_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// ---------------------------------------------------------------------------
// tb_csa_accumulator
//
// Main instance (WIDTH=16, ACC_WIDTH=24, unsigned) is tracked every cycle by
// an arithmetic model: running integer total, beat count, and the group
// phase (accumulating / resolving / holding). Directed sequences add literal
// expectations. Two extra instances cover signed extension and wrap at
// ACC_WIDTH=17 with literal expectations.
// ---------------------------------------------------------------------------
module tb_csa_accumulator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    csa_accumulator_if #(.WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8)) bus_m ();
    csa_accumulator_if #(.WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8)) bus_s ();
    csa_accumulator_if #(.WIDTH(16), .ACC_WIDTH(17), .CNT_WIDTH(8)) bus_w ();

    csa_accumulator #(.WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8), .SIGNED(1'b0))
        dut_m (.clock(clk), .reset(rst), .bus(bus_m));
    csa_accumulator #(.WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8), .SIGNED(1'b1))
        dut_s (.clock(clk), .reset(rst), .bus(bus_s));
    csa_accumulator #(.WIDTH(16), .ACC_WIDTH(17), .CNT_WIDTH(8), .SIGNED(1'b0))
        dut_w (.clock(clk), .reset(rst), .bus(bus_w));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- model of the main instance ----------------
    longint m_total;
    longint m_res;
    int     m_cnt;
    int     m_phase;   // 0 accumulating, 1 resolving, 2 holding
    bit     m_live = 1'b0;
    logic [23:0] m_sc;

    always @(posedge clk) begin
        if (rst) begin
            m_total = 0; m_res = 0; m_cnt = 0; m_phase = 0; m_live = 1'b1;
        end else if (m_live) begin
            case (m_phase)
                0: if (bus_m.in_valid) begin
                    m_total = (m_total + longint'(bus_m.in_0) + longint'(bus_m.in_1)) % (64'sd1 << 24);
                    m_cnt   = (m_cnt + 1) % 256;
                    if (bus_m.in_last) m_phase = 1;
                end
                1: begin
                    m_res   = m_total;
                    m_phase = 2;
                end
                default: if (bus_m.out_ready) begin
                    m_total = 0; m_cnt = 0; m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_in_ready",   bus_m.in_ready,   64'(m_phase == 0));
            chk("m_out_valid",  bus_m.out_valid,  64'(m_phase == 2));
            chk("m_out_result", bus_m.out_result, 64'(m_res));
            if (m_phase == 2) begin
                m_sc = bus_m.out_sum + bus_m.out_carry;
                chk("m_out_count", bus_m.out_count, 64'(m_cnt));
                chk("m_sum_carry", m_sc,            64'(m_res));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send_m(input logic [15:0] a, input logic [15:0] b, input logic last);
        @(negedge clk);
        chk("beat_in_ready", bus_m.in_ready, 1);
        bus_m.in_valid = 1'b1;
        bus_m.in_0     = a;
        bus_m.in_1     = b;
        bus_m.in_last  = last;
        $display("beat a=0x%04h b=0x%04h last=%0b", a, b, last);
    endtask

    task automatic idle_m();
        @(negedge clk);
        bus_m.in_valid = 1'b0;
        bus_m.in_last  = 1'b0;
    endtask

    task automatic handshake_m();
        bus_m.out_ready = 1'b1;
        @(negedge clk);
        bus_m.out_ready = 1'b0;
        chk("post_hs_in_ready",  bus_m.in_ready,  1);
        chk("post_hs_out_valid", bus_m.out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        {bus_m.in_valid, bus_m.in_last, bus_m.out_ready} = '0;
        {bus_s.in_valid, bus_s.in_last, bus_s.out_ready} = '0;
        {bus_w.in_valid, bus_w.in_last, bus_w.out_ready} = '0;
        bus_m.in_0 = '0; bus_m.in_1 = '0;
        bus_s.in_0 = '0; bus_s.in_1 = '0;
        bus_w.in_0 = '0; bus_w.in_1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",   bus_m.in_ready,   1);
        chk("rst_out_valid",  bus_m.out_valid,  0);
        chk("rst_out_result", bus_m.out_result, 0);
        chk("rst_out_sum",    bus_m.out_sum,    0);
        chk("rst_out_carry",  bus_m.out_carry,  0);
        chk("rst_out_count",  bus_m.out_count,  0);
        rst = 1'b0;

        // Single beat 3+5: valid two cycles after acceptance.
        send_m(16'd3, 16'd5, 1'b1);
        idle_m();
        chk("t1_resolve_valid", bus_m.out_valid, 0);
        chk("t1_resolve_ready", bus_m.in_ready,  0);
        @(negedge clk);
        chk("t1_valid",  bus_m.out_valid,  1);
        chk("t1_result", bus_m.out_result, 24'd8);
        chk("t1_count",  bus_m.out_count,  8'd1);
        $display("group1 result=0x%0h count=%0d", bus_m.out_result, bus_m.out_count);
        handshake_m();

        // Four full-scale beats, then five cycles of backpressure with
        // in_valid held high.
        for (int i = 0; i < 4; i++) send_m(16'hFFFF, 16'hFFFF, 1'(i == 3));
        idle_m();
        chk("t2_ready_low_1", bus_m.in_ready, 0);
        bus_m.in_valid = 1'b1;
        bus_m.in_0     = 16'h1234;
        bus_m.in_1     = 16'h4321;
        bus_m.in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", bus_m.in_ready,   0);
            chk("bp_valid",    bus_m.out_valid,  1);
            chk("bp_result",   bus_m.out_result, 24'h07FFF8);
            chk("bp_count",    bus_m.out_count,  8'd4);
        end
        $display("group2 result=0x%0h count=%0d", bus_m.out_result, bus_m.out_count);
        bus_m.out_ready = 1'b1;
        @(negedge clk);
        bus_m.out_ready = 1'b0;
        bus_m.in_valid  = 1'b0;
        bus_m.in_last   = 1'b0;
        chk("bp_post_ready", bus_m.in_ready, 1);

        // Next group starts from zero.
        send_m(16'd1, 16'd1, 1'b1);
        idle_m();
        @(negedge clk);
        chk("t3_result", bus_m.out_result, 24'd2);
        chk("t3_count",  bus_m.out_count,  8'd1);
        $display("group3 result=0x%0h count=%0d", bus_m.out_result, bus_m.out_count);
        handshake_m();

        // Reset mid-group discards the partial sum.
        send_m(16'd10, 16'd20, 1'b0);
        send_m(16'd30, 16'd40, 1'b0);
        @(negedge clk);
        bus_m.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_out_valid",  bus_m.out_valid,  0);
        chk("mr_in_ready",   bus_m.in_ready,   1);
        chk("mr_out_count",  bus_m.out_count,  0);
        chk("mr_out_result", bus_m.out_result, 0);
        send_m(16'd7, 16'd0, 1'b1);
        idle_m();
        @(negedge clk);
        chk("t4_result", bus_m.out_result, 24'd7);
        chk("t4_count",  bus_m.out_count,  8'd1);
        $display("group4 result=0x%0h count=%0d", bus_m.out_result, bus_m.out_count);
        handshake_m();

        // Signed instance: -1 + 2 + -32768 + 0 = -32767.
        @(negedge clk);
        bus_s.in_valid = 1'b1; bus_s.in_0 = 16'hFFFF; bus_s.in_1 = 16'h0002; bus_s.in_last = 1'b0;
        @(negedge clk);
        bus_s.in_0 = 16'h8000; bus_s.in_1 = 16'h0000; bus_s.in_last = 1'b1;
        @(negedge clk);
        bus_s.in_valid = 1'b0; bus_s.in_last = 1'b0;
        n = 0;
        while (!bus_s.out_valid && n < 8) begin @(negedge clk); n++; end
        chk("s_valid",  bus_s.out_valid,  1);
        chk("s_result", bus_s.out_result, 24'hFF8001);
        chk("s_count",  bus_s.out_count,  8'd2);
        m_sc = bus_s.out_sum + bus_s.out_carry;
        chk("s_sum_carry", m_sc, 24'hFF8001);
        $display("signed result=0x%0h count=%0d", bus_s.out_result, bus_s.out_count);
        bus_s.out_ready = 1'b1;
        @(negedge clk);
        bus_s.out_ready = 1'b0;

        // Wrap instance: 6*0xFFFF mod 2^17.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_w.in_valid = 1'b1; bus_w.in_0 = 16'hFFFF; bus_w.in_1 = 16'hFFFF;
            bus_w.in_last  = 1'(i == 2);
        end
        @(negedge clk);
        bus_w.in_valid = 1'b0; bus_w.in_last = 1'b0;
        n = 0;
        while (!bus_w.out_valid && n < 8) begin @(negedge clk); n++; end
        chk("w_valid",  bus_w.out_valid,  1);
        chk("w_result", bus_w.out_result, 17'h1FFFA);
        chk("w_count",  bus_w.out_count,  8'd3);
        chk("w_sum_carry", 17'(bus_w.out_sum + bus_w.out_carry), 17'h1FFFA);
        $display("wrap result=0x%0h count=%0d", bus_w.out_result, bus_w.out_count);
        bus_w.out_ready = 1'b1;
        @(negedge clk);
        bus_w.out_ready = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
